// File: rtl/verilog_pattern_fill.sv
// Pattern-fill stream source: emits N beats of a replicated 8/16/32-bit element,
// optionally stepping the element per beat and pacing itself on a discarded input stream.
module verilog_pattern_fill #(
    parameter int DataWidth  = 512,
    parameter int CountWidth = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ext_data_i_ready,
    input  logic                  ext_data_i_valid,
    input  logic [DataWidth-1:0]  ext_data_i_bits,
    input  logic                  ext_data_o_ready,
    output logic                  ext_data_o_valid,
    output logic [DataWidth-1:0]  ext_data_o_bits,
    input  logic [31:0]           ext_csr_i_0,
    input  logic [31:0]           ext_csr_i_1,
    input  logic [31:0]           ext_csr_i_2,
    input  logic [31:0]           ext_csr_i_3,
    input  logic                  ext_start_i,
    output logic                  ext_busy_o,
    output logic [CountWidth-1:0] ext_beats_o
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CountWidth-1:0] COUNT_ONE = CountWidth'(1);

    state_t                state_reg, state_next;
    logic [31:0]           cur_val_reg;
    logic [31:0]           step_reg;
    logic [CountWidth-1:0] count_reg;
    logic [CountWidth-1:0] beats_reg;
    logic [1:0]            size_reg;
    logic                  incr_reg;
    logic                  consume_reg;

    logic run;
    logic start_ok;
    logic transfer;
    logic last_beat;

    assign run       = (state_reg == RUN);
    assign start_ok  = (state_reg == IDLE) && ext_start_i;
    assign transfer  = ext_data_o_valid && ext_data_o_ready;
    assign last_beat = (beats_reg == (count_reg - COUNT_ONE));

    assign ext_data_o_valid = run && (!consume_reg || ext_data_i_valid);
    assign ext_data_i_ready = run && consume_reg && ext_data_o_ready;
    assign ext_busy_o       = run;
    assign ext_beats_o      = beats_reg;

    // Input payload and reserved CSR bits are intentionally ignored.
    logic unused_inputs;
    assign unused_inputs = ^{ext_data_i_bits, ext_csr_i_1[31:CountWidth], ext_csr_i_2[31:4]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (ext_start_i && (ext_csr_i_1[CountWidth-1:0] != '0)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (transfer && last_beat) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_val_reg <= '0;
            step_reg    <= '0;
            count_reg   <= '0;
            beats_reg   <= '0;
            size_reg    <= '0;
            incr_reg    <= 1'b0;
            consume_reg <= 1'b0;
        end else if (start_ok) begin
            cur_val_reg <= ext_csr_i_0;
            step_reg    <= ext_csr_i_3;
            count_reg   <= ext_csr_i_1[CountWidth-1:0];
            size_reg    <= ext_csr_i_2[1:0];
            incr_reg    <= ext_csr_i_2[2];
            consume_reg <= ext_csr_i_2[3];
            beats_reg   <= '0;
        end else if (run && transfer) begin
            beats_reg <= beats_reg + COUNT_ONE;
            // Skip the step on the final beat so the bus keeps showing the last emitted element.
            if (incr_reg && !last_beat) begin
                cur_val_reg <= cur_val_reg + step_reg;
            end
        end
    end

    logic [DataWidth-1:0] rep8, rep16, rep32;

    for (genvar gi = 0; gi < DataWidth / 32; gi++) begin : g_rep
        assign rep32[gi*32 +: 32] = cur_val_reg;
        assign rep16[gi*32 +: 32] = {2{cur_val_reg[15:0]}};
        assign rep8[gi*32 +: 32]  = {4{cur_val_reg[7:0]}};
    end

    always_comb begin
        ext_data_o_bits = rep32;
        case (size_reg)
            2'd0:    ext_data_o_bits = rep8;
            2'd1:    ext_data_o_bits = rep16;
            default: ext_data_o_bits = rep32;
        endcase
    end

endmodule

// File: tb/tb_verilog_pattern_fill.sv
// Randomised bench for verilog_pattern_fill against an arithmetic reference model
// (element k = base + k*step, replicated at the selected element width).
module tb_verilog_pattern_fill;

    localparam int DW = 512;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_ready, i_valid, o_ready, o_valid;
    logic [DW-1:0] i_bits, o_bits;
    logic [31:0]   csr0, csr1, csr2, csr3;
    logic          start, busy;
    logic [CW-1:0] beats;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    verilog_pattern_fill #(.DataWidth(DW), .CountWidth(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ext_data_i_ready (i_ready),
        .ext_data_i_valid (i_valid),
        .ext_data_i_bits  (i_bits),
        .ext_data_o_ready (o_ready),
        .ext_data_o_valid (o_valid),
        .ext_data_o_bits  (o_bits),
        .ext_csr_i_0      (csr0),
        .ext_csr_i_1      (csr1),
        .ext_csr_i_2      (csr2),
        .ext_csr_i_3      (csr3),
        .ext_start_i      (start),
        .ext_busy_o       (busy),
        .ext_beats_o      (beats)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit b of the beat is bit (b mod E) of the element.
    function automatic logic [DW-1:0] model_beat(input logic [31:0] v, input logic [1:0] sz);
        int e;
        logic [DW-1:0] r;
        e = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        for (int b = 0; b < DW; b++) r[b] = v[b % e];
        return r;
    endfunction

    // vld_mode: 0 random, 1 toggle 1010.., 2 always high
    task automatic run_job(input logic [31:0] base, input int n, input logic [1:0] sz,
                           input bit incr, input bit cons, input logic [31:0] step,
                           input int rdy_pct, input int vld_mode, input bit disturb);
        int            k, cyc, pops;
        logic [31:0]   kk, exp_val;
        logic          exp_valid, stalled;
        logic [DW-1:0] prev_bits;
        @(negedge clk);
        csr0  = base;
        csr1  = {16'h0, 16'(n)};
        csr2  = {28'h0, cons, incr, sz};
        csr3  = step;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0; pops = 0; stalled = 1'b0; prev_bits = '0;
        if (n == 0) begin
            for (int i = 0; i < 3; i++) begin
                #1;
                check("n0_busy", busy, 1'b0);
                check("n0_valid", o_valid, 1'b0);
                check("n0_beats", beats, '0);
                @(negedge clk);
            end
            return;
        end
        while (k < n && cyc < 400) begin
            o_ready = ($urandom_range(99) < rdy_pct);
            i_valid = (vld_mode == 1) ? (cyc % 2 == 0) : (vld_mode == 2) ? 1'b1 : 1'($urandom_range(1));
            i_bits  = {16{$urandom()}};
            if (disturb && cyc == 3) begin
                start = 1'b1;
                csr0  = ~base;
                csr1  = 32'd1;
                csr2  = 32'h0;
                csr3  = 32'h1234;
            end else begin
                start = 1'b0;
            end
            #1;
            kk        = 32'(k);
            exp_val   = incr ? base + kk * step : base;
            exp_valid = !cons || i_valid;
            check("run_busy", busy, 1'b1);
            check("run_valid", o_valid, exp_valid);
            check("run_iready", i_ready, cons && o_ready);
            check("run_beats", beats, CW'(k));
            check("run_bits", o_bits, model_beat(exp_val, sz));
            if (stalled) check("stall_hold", o_bits, prev_bits);
            stalled   = exp_valid && !o_ready;
            prev_bits = o_bits;
            if (i_ready && i_valid) pops++;
            if (exp_valid && o_ready) k++;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; o_ready = 1'b0; i_valid = 1'b0;
        #1;
        check("job_done", k, n);
        check("end_busy", busy, 1'b0);
        check("end_valid", o_valid, 1'b0);
        check("end_iready", i_ready, 1'b0);
        check("end_beats", beats, CW'(n));
        check("end_pops", pops, cons ? n : 0);
        $display("job base=%08h n=%0d sz=%0d incr=%0d cons=%0d step=%08h cycles=%0d", base, n, sz, incr, cons, step, cyc);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; o_ready = 1'b0; i_valid = 1'b0; i_bits = '0;
        csr0 = '0; csr1 = '0; csr2 = '0; csr3 = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_iready", i_ready, 1'b0);
        check("rst_beats", beats, '0);
        check("rst_bits", o_bits, '0);
        @(negedge clk);
        rst = 1'b0;

        run_job(32'h000000A5, 4, 2'd0, 1'b0, 1'b0, 32'h0, 100, 2, 1'b0);
        run_job(32'h0000FFFE, 3, 2'd1, 1'b1, 1'b0, 32'h1, 100, 2, 1'b0);
        run_job($urandom(), 5, 2'd2, 1'b0, 1'b1, 32'h0, 100, 1, 1'b0);
        run_job($urandom(), 8, 2'($urandom_range(3)), 1'b1, 1'b0, $urandom(), 50, 2, 1'b1);
        run_job($urandom(), 0, 2'd2, 1'b0, 1'b0, 32'h0, 100, 2, 1'b0);

        // Asynchronous reset two beats into a six-beat job.
        @(negedge clk);
        csr0 = 32'hDEADBEEF; csr1 = 32'd6; csr2 = 32'h2; csr3 = 32'h0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; o_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_beats", beats, CW'(2));
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", o_valid, 1'b0);
        check("mid_rst_beats", beats, '0);
        check("mid_rst_bits", o_bits, '0);
        @(negedge clk);
        rst = 1'b0; o_ready = 1'b0;

        for (int j = 0; j < 10; j++) begin
            run_job($urandom(), $urandom_range(1, 12), 2'($urandom_range(3)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), $urandom(), $urandom_range(30, 100), 0, j % 3 == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
